// File: rtl/rom_fetch_arbiter.sv
// ============================================================================
// rom_fetch_arbiter: single-port ROM scheduler, display fetch strictly over aux
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_fetch_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_valid,
  output logic [DATA_W-1:0] aux_data,
  output logic [7:0]        aux_wait,
  output logic              aux_starved,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int STAGES = ROM_LAT + 1;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic              gnt_w;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_en_q, rom_en_d;
  logic [1:0]        tag_q [STAGES];
  logic [7:0]        aux_wait_q, aux_wait_d;
  logic              aux_starved_q, aux_starved_d;
  logic              aux_blocked_w;

  // Grant is forced low during reset so aux never sees a phantom accept.
  assign gnt_w         = rst_n & aux_req & ~disp_req;
  assign aux_blocked_w = aux_req & ~gnt_w;

  always_comb begin
    rom_addr_d    = rom_addr_q;
    rom_en_d      = disp_req | aux_req;
    aux_wait_d    = 8'd0;
    aux_starved_d = aux_starved_q;

    if (disp_req) begin
      rom_addr_d = disp_addr;
    end else if (aux_req) begin
      rom_addr_d = aux_addr;
    end

    if (aux_blocked_w) begin
      aux_wait_d = (aux_wait_q == 8'hFF) ? 8'hFF : aux_wait_q + 8'd1;
    end

    // Clear takes precedence over a set in the same cycle.
    if (starve_clr) begin
      aux_starved_d = 1'b0;
    end else if (aux_blocked_w && (aux_wait_q >= WAIT_LIMIT)) begin
      aux_starved_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr_q    <= '0;
      rom_en_q      <= 1'b0;
      aux_wait_q    <= 8'd0;
      aux_starved_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= 2'b00;
      end
    end else begin
      rom_addr_q    <= rom_addr_d;
      rom_en_q      <= rom_en_d;
      aux_wait_q    <= aux_wait_d;
      aux_starved_q <= aux_starved_d;
      tag_q[0]      <= {disp_req, gnt_w};
      for (int i = 1; i < STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign aux_gnt     = gnt_w;
  assign rom_addr    = rom_addr_q;
  assign rom_en      = rom_en_q;
  assign aux_wait    = aux_wait_q;
  assign aux_starved = aux_starved_q;
  assign disp_valid  = tag_q[ROM_LAT][1];
  assign aux_valid   = tag_q[ROM_LAT][0];
  assign disp_data   = disp_valid ? rom_data : '0;
  assign aux_data    = aux_valid  ? rom_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
// ============================================================================
// tb_rom_fetch_arbiter: vector-table bench with a 1-cycle ROM returning a[7:0]
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_fetch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_req;
  logic [8:0] disp_addr;
  logic       disp_valid;
  logic [7:0] disp_data;
  logic       aux_req;
  logic [8:0] aux_addr;
  logic       aux_gnt;
  logic       aux_valid;
  logic [7:0] aux_data;
  logic [7:0] aux_wait;
  logic       aux_starved;
  logic       starve_clr;
  logic [8:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr[7:0];

  rom_fetch_arbiter #(
    .ADDR_W  (9),
    .DATA_W  (8),
    .ROM_LAT (1),
    .MAX_WAIT(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_gnt    (aux_gnt),
    .aux_valid  (aux_valid),
    .aux_data   (aux_data),
    .aux_wait   (aux_wait),
    .aux_starved(aux_starved),
    .starve_clr (starve_clr),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data)
  );

  typedef struct {
    logic       chk;
    logic       rst_n;
    logic       dr;
    logic [8:0] da;
    logic       ar;
    logic [8:0] aa;
    logic       clr;
    logic       gnt;
    logic       dv;
    logic [7:0] dd;
    logic       av;
    logic [7:0] ad;
    logic [7:0] wt;
    logic       st;
    logic       en;
    logic [8:0] ra;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic c, logic r, logic dr, logic [8:0] da, logic ar, logic [8:0] aa, logic clr,
    logic gnt, logic dv, logic [7:0] dd, logic av, logic [7:0] ad, logic [7:0] wt,
    logic st, logic en, logic [8:0] ra);
    vec_t v;
    v.chk = c;  v.rst_n = r; v.dr = dr; v.da = da; v.ar = ar; v.aa = aa; v.clr = clr;
    v.gnt = gnt; v.dv = dv; v.dd = dd; v.av = av; v.ad = ad; v.wt = wt;
    v.st = st;  v.en = en;  v.ra = ra;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic dr, input logic [8:0] da,
                       input logic ar, input logic [8:0] aa, input logic clr);
    @(negedge clk);
    rst_n = r; disp_req = dr; disp_addr = da; aux_req = ar; aux_addr = aa; starve_clr = clr;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0; aux_req = 1'b0; aux_addr = '0; starve_clr = 1'b0;

    // Reset held with both requests active, then release.
    vecs.push_back(mk(0,0,1,9'h055,1,9'h066,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,0,1,9'h055,1,9'h066,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,0,1,9'h055,1,9'h066,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,1,0,9'h000,1,9'h066,0, 1,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,1,9'h066));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,1,8'h66,8'd0,0,0,9'h066));
    // Display-only burst.
    vecs.push_back(mk(1,1,1,9'h010,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h066));
    vecs.push_back(mk(1,1,1,9'h011,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,1,9'h010));
    vecs.push_back(mk(1,1,1,9'h012,0,9'h000,0, 0,1,8'h10,0,8'h00,8'd0,0,1,9'h011));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,1,8'h11,0,8'h00,8'd0,0,1,9'h012));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,1,8'h12,0,8'h00,8'd0,0,0,9'h012));
    // Contention: display holds slots 0-4, aux granted in slot 5.
    vecs.push_back(mk(1,1,1,9'h040,1,9'h1A5,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h012));
    vecs.push_back(mk(1,1,1,9'h041,1,9'h1A5,0, 0,0,8'h00,0,8'h00,8'd1,0,1,9'h040));
    vecs.push_back(mk(1,1,1,9'h042,1,9'h1A5,0, 0,1,8'h40,0,8'h00,8'd2,0,1,9'h041));
    vecs.push_back(mk(1,1,1,9'h043,1,9'h1A5,0, 0,1,8'h41,0,8'h00,8'd3,0,1,9'h042));
    vecs.push_back(mk(1,1,1,9'h044,1,9'h1A5,0, 0,1,8'h42,0,8'h00,8'd4,0,1,9'h043));
    vecs.push_back(mk(1,1,0,9'h000,1,9'h1A5,0, 1,1,8'h43,0,8'h00,8'd5,0,1,9'h044));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,1,8'h44,0,8'h00,8'd0,0,1,9'h1A5));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,1,8'hA5,8'd0,0,0,9'h1A5));
    // Interleaved owners.
    vecs.push_back(mk(1,1,1,9'h020,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h1A5));
    vecs.push_back(mk(1,1,0,9'h000,1,9'h130,0, 1,0,8'h00,0,8'h00,8'd0,0,1,9'h020));
    vecs.push_back(mk(1,1,1,9'h021,0,9'h000,0, 0,1,8'h20,0,8'h00,8'd0,0,1,9'h130));
    vecs.push_back(mk(1,1,0,9'h000,1,9'h131,0, 1,0,8'h00,1,8'h30,8'd0,0,1,9'h021));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,1,8'h21,0,8'h00,8'd0,0,1,9'h131));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,1,8'h31,8'd0,0,0,9'h131));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h131));
    // Aux accepted, then reset in the following cycle discards it.
    vecs.push_back(mk(1,1,0,9'h000,1,9'h0F0,0, 1,0,8'h00,0,8'h00,8'd0,0,0,9'h131));
    vecs.push_back(mk(1,0,0,9'h000,1,9'h0F1,0, 0,0,8'h00,0,8'h00,8'd0,0,1,9'h0F0));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));
    vecs.push_back(mk(1,1,0,9'h000,0,9'h000,0, 0,0,8'h00,0,8'h00,8'd0,0,0,9'h000));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].dr, vecs[i].da, vecs[i].ar, vecs[i].aa, vecs[i].clr);
      if (vecs[i].chk) begin
        cmp("aux_gnt",     i, 32'(aux_gnt),     32'(vecs[i].gnt));
        cmp("disp_valid",  i, 32'(disp_valid),  32'(vecs[i].dv));
        cmp("disp_data",   i, 32'(disp_data),   32'(vecs[i].dd));
        cmp("aux_valid",   i, 32'(aux_valid),   32'(vecs[i].av));
        cmp("aux_data",    i, 32'(aux_data),    32'(vecs[i].ad));
        cmp("aux_wait",    i, 32'(aux_wait),    32'(vecs[i].wt));
        cmp("aux_starved", i, 32'(aux_starved), 32'(vecs[i].st));
        cmp("rom_en",      i, 32'(rom_en),      32'(vecs[i].en));
        cmp("rom_addr",    i, 32'(rom_addr),    32'(vecs[i].ra));
      end
    end

    // Starvation: display owns 300 consecutive slots with aux pending.
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 1'b1, 9'(k), 1'b1, 9'h1FF, 1'b0);
      cmp("starve_gnt",  k, 32'(aux_gnt), 32'd0);
      cmp("starve_wait", k, 32'(aux_wait), (k > 255) ? 32'd255 : 32'(k));
      cmp("starve_flag", k, 32'(aux_starved), (k >= 11) ? 32'd1 : 32'd0);
      cmp("valid_excl",  k, 32'(disp_valid & aux_valid), 32'd0);
    end

    // Clear pulse while still blocked: drops for one cycle then re-sets.
    drive(1'b1, 1'b1, 9'h000, 1'b1, 9'h1FF, 1'b1);
    cmp("clr_flag", 0, 32'(aux_starved), 32'd1);
    cmp("clr_wait", 0, 32'(aux_wait), 32'd255);
    drive(1'b1, 1'b1, 9'h001, 1'b1, 9'h1FF, 1'b0);
    cmp("clr_flag", 1, 32'(aux_starved), 32'd0);
    cmp("clr_wait", 1, 32'(aux_wait), 32'd255);
    drive(1'b1, 1'b1, 9'h002, 1'b1, 9'h1FF, 1'b0);
    cmp("clr_flag", 2, 32'(aux_starved), 32'd1);
    // Display releases: aux granted, flag stays sticky, wait returns to 0.
    drive(1'b1, 1'b0, 9'h000, 1'b1, 9'h1FF, 1'b0);
    cmp("rel_gnt",  0, 32'(aux_gnt), 32'd1);
    cmp("rel_wait", 0, 32'(aux_wait), 32'd255);
    drive(1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    cmp("rel_wait", 1, 32'(aux_wait), 32'd0);
    cmp("rel_flag", 1, 32'(aux_starved), 32'd1);
    drive(1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    drive(1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0);
    cmp("rel_flag", 2, 32'(aux_starved), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
